// File: rtl/writemem_seq.sv
// writemem_seq: burst writer that streams bytes into a 2**ADDR_W x DATA_W memory
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_start               begin a burst (sampled only in IDLE)
//   i_base_addr, i_len    first address and word count, captured on accepted start
//   i_in_valid, i_in_data write stream; o_in_ready high while loading
//   o_busy, o_done        FSM not idle / one-cycle burst-complete pulse
//   o_wr_count            words accepted in current/last burst
//   i_rd_addr, o_rd_data  combinational read port
//   o_checksum            running byte sum, present only with WRITEMEM_CHECKSUM_EN defined
module writemem_seq #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_len,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_wr_count,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
`ifdef WRITEMEM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] o_checksum
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_rem;
  logic [ADDR_W:0]     r_wr_count;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_done;
  logic [DATA_W-1:0]   r_mem [2**ADDR_W];
  logic                w_beat;
  logic                w_last;
  assign w_beat     = i_in_valid && r_in_ready;
  assign w_last     = r_rem == {{ADDR_W{1'b0}}, 1'b1};
  assign o_in_ready = r_in_ready;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_wr_count = r_wr_count;
  assign o_rd_data  = r_mem[i_rd_addr];
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_rem      <= '0;
      r_wr_count <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_ptr      <= i_base_addr;
          r_rem      <= i_len;
          r_wr_count <= '0;
          r_busy     <= 1'b1;
          r_state    <= (i_len == '0) ? DONE : LOAD;
          r_done     <= i_len == '0;
          r_in_ready <= i_len != '0;
        end
        LOAD: if (w_beat) begin
          r_ptr      <= r_ptr + 1'b1;
          r_rem      <= r_rem - 1'b1;
          r_wr_count <= r_wr_count + 1'b1;
          r_state    <= w_last ? DONE : LOAD;
          r_done     <= w_last;
          r_in_ready <= !w_last;
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // Storage is never cleared; a beat coinciding with reset is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_beat) r_mem[r_ptr] <= i_in_data;
  end
`ifdef WRITEMEM_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;
  assign o_checksum = r_checksum;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_checksum <= '0;
    else if (r_state == IDLE && i_start) r_checksum <= '0;
    else if (w_beat) r_checksum <= r_checksum + i_in_data;
  end
`endif
endmodule

// File: tb/tb_writemem_seq.sv
// tb_writemem_seq: scoreboard bench for writemem_seq bursts, stalls, wrap, reset abort
module tb_writemem_seq;
  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] i_base_addr = '0;
  logic [8:0] i_len = '0;
  logic       i_in_valid = 1'b0;
  logic [7:0] i_in_data = '0;
  logic       o_in_ready;
  logic       o_busy;
  logic       o_done;
  logic [8:0] o_wr_count;
  logic [7:0] i_rd_addr = '0;
  logic [7:0] o_rd_data;
`ifdef WRITEMEM_CHECKSUM_EN
  logic [7:0] o_checksum;
`endif
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {logic [8:0] cnt; logic [7:0] cs;} exp_t;
  exp_t sb[$];
  writemem_seq dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_len(i_len), .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
    .o_busy(o_busy), .o_done(o_done), .o_wr_count(o_wr_count), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data)
`ifdef WRITEMEM_CHECKSUM_EN
    , .o_checksum(o_checksum)
`endif
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Every done pulse must match the oldest outstanding expected burst result.
  always @(negedge i_clk) begin
    if (o_done === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_done: got done=1 expected no pulse (wr_count %h)", o_wr_count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_wr_count", 32'(o_wr_count), 32'(e.cnt));
        chk("done_busy", 32'(o_busy), 32'd1);
`ifdef WRITEMEM_CHECKSUM_EN
        chk("done_checksum", 32'(o_checksum), 32'(e.cs));
`endif
      end
    end
  end
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic rd(input logic [7:0] a, input logic [7:0] exp);
    i_rd_addr = a;
    #1;
    chk($sformatf("mem[%02h]", a), 32'(o_rd_data), 32'(exp));
  endtask
  task automatic burst(input logic [7:0] base, input logic [7:0] d[$], input bit gaps,
                       input int start_at);
    i_start = 1'b1;
    i_base_addr = base;
    i_len = 9'(d.size());
    tick();
    i_start = 1'b0;
    i_base_addr = 8'h55;
    i_len = 9'd7;
    chk("ready_after_start", 32'(o_in_ready), 32'd1);
    for (int i = 0; i < d.size(); i++) begin
      if (gaps && i > 0) begin
        i_in_valid = 1'b0;
        i_in_data = 8'hEE;
        tick();
        chk("ready_in_gap", 32'(o_in_ready), 32'd1);
      end
      i_in_valid = 1'b1;
      i_in_data = d[i];
      if (i == start_at) begin
        i_start = 1'b1;
        i_base_addr = 8'h80;
        i_len = 9'd1;
      end
      tick();
      i_in_valid = 1'b0;
      i_start = 1'b0;
      if (i < d.size() - 1) chk("ready_mid", 32'(o_in_ready), 32'd1);
    end
    chk("done_after_last", 32'(o_done), 32'd1);
    chk("ready_low_done", 32'(o_in_ready), 32'd0);
    tick();
    chk("done_one_cycle", 32'(o_done), 32'd0);
    chk("busy_idle", 32'(o_busy), 32'd0);
  endtask
  initial begin
    logic [7:0] d[$];
    // 1: reset with garbage on the inputs
    i_start = 1'b1;
    i_in_valid = 1'b1;
    i_in_data = 8'h3C;
    i_len = 9'd3;
    tick();
    i_in_data = 8'hC3;
    tick();
    i_start = 1'b0;
    i_in_valid = 1'b0;
    chk("rst_ready", 32'(o_in_ready), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_wr_count", 32'(o_wr_count), 32'd0);
    i_rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(o_in_ready), 32'd0);
    // 2: back-to-back burst at 0x10
    sb.push_back('{cnt: 9'd4, cs: 8'h0A});
    d = '{8'h01, 8'h02, 8'h03, 8'h04};
    burst(8'h10, d, 1'b0, -1);
    rd(8'h10, 8'h01); rd(8'h11, 8'h02); rd(8'h12, 8'h03); rd(8'h13, 8'h04);
    chk("wr_count_holds", 32'(o_wr_count), 32'd4);
    // 3: wrapping burst with in_valid gaps
    sb.push_back('{cnt: 9'd3, cs: 8'h31});
    d = '{8'hAA, 8'hBB, 8'hCC};
    burst(8'hFE, d, 1'b1, -1);
    rd(8'hFE, 8'hAA); rd(8'hFF, 8'hBB); rd(8'h00, 8'hCC);
    // 4: zero-length burst
    sb.push_back('{cnt: 9'd0, cs: 8'h00});
    i_start = 1'b1;
    i_base_addr = 8'h10;
    i_len = 9'd0;
    i_in_valid = 1'b1;
    i_in_data = 8'h99;
    tick();
    i_start = 1'b0;
    chk("zl_done", 32'(o_done), 32'd1);
    chk("zl_busy", 32'(o_busy), 32'd1);
    chk("zl_ready", 32'(o_in_ready), 32'd0);
    tick();
    i_in_valid = 1'b0;
    chk("zl_busy_low", 32'(o_busy), 32'd0);
    chk("zl_done_low", 32'(o_done), 32'd0);
    rd(8'h10, 8'h01);
    // 5: restart during a burst is ignored
    sb.push_back('{cnt: 9'd1, cs: 8'h5A});
    d = '{8'h5A};
    burst(8'h80, d, 1'b0, -1);
    sb.push_back('{cnt: 9'd4, cs: 8'hAA});
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    burst(8'h40, d, 1'b0, 1);
    rd(8'h40, 8'h11); rd(8'h41, 8'h22); rd(8'h42, 8'h33); rd(8'h43, 8'h44);
    rd(8'h80, 8'h5A);
    // 6: reset after 2 of 5 beats
    i_start = 1'b1;
    i_base_addr = 8'h20;
    i_len = 9'd5;
    tick();
    i_start = 1'b0;
    i_in_valid = 1'b1;
    i_in_data = 8'h61;
    tick();
    i_in_data = 8'h62;
    tick();
    chk("abort_pre_count", 32'(o_wr_count), 32'd2);
    i_in_data = 8'h63;
    i_rst_n = 1'b0;
    tick();
    i_in_valid = 1'b0;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_ready", 32'(o_in_ready), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    chk("abort_count", 32'(o_wr_count), 32'd0);
    i_rst_n = 1'b1;
    tick();
    tick();
    rd(8'h20, 8'h61); rd(8'h21, 8'h62);
    // full-depth burst: every address once, data equals offset from base
    sb.push_back('{cnt: 9'd256, cs: 8'h80});
    d = {};
    for (int i = 0; i < 256; i++) d.push_back(8'(i));
    burst(8'h33, d, 1'b0, -1);
    rd(8'h33, 8'h00); rd(8'h32, 8'hFF); rd(8'hFF, 8'hCC); rd(8'h00, 8'hCD);
    chk("full_count", 32'(o_wr_count), 32'd256);
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
